matrix_index_sequencer: RTL and testbench

Generates the (row, col) index stream that drives the covariance/correlation accumulation stage of the LCMV datapath. It walks a runtime-sized n×n matrix in row-major order, either fully or upper-triangular only, since R is symmetric. It presents one index pair per cycle over a valid/ready handshake to the downstream multiply-accumulate and storage stage. It is built from nested wrap-at-limit counters and a small control FSM.

---
 rtl/lcmv_pkg.sv | 22 ++
 rtl/wrap_counter.sv | 39 +++
 rtl/matrix_index_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_matrix_index_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcmv_pkg.sv
// Shared definitions for the LCMV datapath control blocks: the matrix
// dimension default, the index width derivation and the sequencer states.
package lcmv_pkg;

  // Default maximum matrix dimension (number of spectral bands).
  localparam int N_MAX_DEFAULT = 16;

  // Index width needed to address 0 .. n_max-1 (never narrower than 1 bit).
  function automatic int idx_width_for(input int n_max);
    return (n_max > 1) ? $clog2(n_max) : 1;
  endfunction

  localparam int IDX_WIDTH_DEFAULT = idx_width_for(N_MAX_DEFAULT);

  // Control states of the index sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that wraps to zero after reaching a runtime limit, with
// synchronous clear and load. at_limit flags value == limit.
module wrap_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value,
  output logic             at_limit
);

  logic [WIDTH-1:0] value_r;

  // Count register: clear has priority over load, load over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      value_r <= {WIDTH{1'b0}};
    end else if (load) begin
      value_r <= load_value;
    end else if (up) begin
      if (at_limit) begin
        value_r <= {WIDTH{1'b0}};
      end else begin
        value_r <= value_r + WIDTH'(1);
      end
    end
  end

  assign value    = value_r;
  assign at_limit = (value_r == limit);

endmodule

// File: rtl/matrix_index_sequencer.sv
// Walks an n x n matrix in row-major order (full or upper-triangular) and
// presents one (row, col) pair per cycle over a valid/ready handshake to the
// covariance accumulation stage.
module matrix_index_sequencer
  import lcmv_pkg::*;
#(
  parameter int N_MAX     = N_MAX_DEFAULT,
  parameter int IDX_WIDTH = idx_width_for(N_MAX)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDX_WIDTH:0]   n,
  input  logic                 triangular,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_WIDTH-1:0] row,
  output logic [IDX_WIDTH-1:0] col,
  output logic                 last_col,
  output logic                 last,
  output logic                 done
);

  // Index arithmetic runs one bit wider than the indices so that n_r, n_r-1
  // and row+1 are all representable without wrap.
  localparam int             CW      = IDX_WIDTH + 1;
  localparam logic [CW-1:0]  N_MAX_C = CW'(N_MAX);
  localparam logic [CW-1:0]  ONE_C   = CW'(1);
  localparam logic [CW-1:0]  ZERO_C  = CW'(0);

  seq_state_t    state_r;
  seq_state_t    state_next_s;
  logic [CW-1:0] n_r;
  logic          tri_r;

  logic [CW-1:0] n_clamp_s;
  logic [CW-1:0] limit_s;
  logic [CW-1:0] row_val_s;
  logic [CW-1:0] col_val_s;
  logic [CW-1:0] col_load_val_s;
  logic          start_ok_s;
  logic          hs_s;
  logic          row_at_s;
  logic          col_at_s;
  logic          last_col_s;
  logic          last_s;
  logic          cnt_clear_s;
  logic          col_up_s;
  logic          col_load_s;
  logic          row_up_s;
  logic          idx_msb_unused_s;

  assign n_clamp_s  = (n > N_MAX_C) ? N_MAX_C : n;
  assign start_ok_s = (state_r == IDLE) && start;
  assign limit_s    = n_r - ONE_C;

  // Flags come only from registered state and counters, never from out_ready.
  assign hs_s       = (state_r == RUN) && out_ready;
  assign last_col_s = (state_r == RUN) && col_at_s;
  assign last_s     = last_col_s && row_at_s;

  // Sweep configuration captured on an accepted start; ignored afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r   <= ZERO_C;
      tri_r <= 1'b0;
    end else if (start_ok_s) begin
      n_r   <= n_clamp_s;
      tri_r <= triangular;
    end
  end

  // Counter control: advance only on a handshake, restart on start and
  // after the final pair so the indices rest at (0,0) between sweeps.
  always_comb begin
    cnt_clear_s    = 1'b0;
    col_up_s       = 1'b0;
    col_load_s     = 1'b0;
    row_up_s       = 1'b0;
    col_load_val_s = ZERO_C;
    if (start_ok_s || (hs_s && last_s)) begin
      cnt_clear_s = 1'b1;
    end else if (hs_s && col_at_s) begin
      row_up_s       = 1'b1;
      col_load_s     = 1'b1;
      col_load_val_s = tri_r ? (row_val_s + ONE_C) : ZERO_C;
    end else if (hs_s) begin
      col_up_s = 1'b1;
    end else begin
      cnt_clear_s = 1'b0;
    end
  end

  wrap_counter #(.WIDTH(CW)) u_row_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear_s),
    .load       (1'b0),
    .load_value (ZERO_C),
    .up         (row_up_s),
    .limit      (limit_s),
    .value      (row_val_s),
    .at_limit   (row_at_s)
  );

  wrap_counter #(.WIDTH(CW)) u_col_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear_s),
    .load       (col_load_s),
    .load_value (col_load_val_s),
    .up         (col_up_s),
    .limit      (limit_s),
    .value      (col_val_s),
    .at_limit   (col_at_s)
  );

  // Index MSBs only guard the arithmetic; they are never set on the outputs.
  assign idx_msb_unused_s = row_val_s[IDX_WIDTH] ^ col_val_s[IDX_WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (n_clamp_s == ZERO_C) ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (hs_s && last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
      end
      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign row      = row_val_s[IDX_WIDTH-1:0];
  assign col      = col_val_s[IDX_WIDTH-1:0];
  assign last_col = last_col_s;
  assign last     = last_s;

endmodule

// File: tb/tb_matrix_index_sequencer.sv
// Scoreboard bench for matrix_index_sequencer: expected pairs are queued when
// a sweep is launched and popped as handshakes occur.
module tb_matrix_index_sequencer;

  localparam int N_MAX = 16;
  localparam int IW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          triangular = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW:0]   n = 5'd0;
  logic          busy, out_valid, last_col, last, done;
  logic [IW-1:0] row, col;

  typedef struct packed {
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic          lc;
    logic          l;
  } pair_t;

  pair_t exp_q[$];
  int    n_errors = 0;
  int    n_checks = 0;
  int    hs_count = 0;
  logic  held_v = 1'b0;
  pair_t held_p;

  always #5 clk = ~clk;

  matrix_index_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n          (n),
    .triangular (triangular),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .row        (row),
    .col        (col),
    .last_col   (last_col),
    .last       (last),
    .done       (done)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int k);
    if (mode == 0) return 1'b1;
    return ((k % 4) == 0) || ((k % 4) == 3);
  endfunction

  // Monitor: hold stability under backpressure, scoreboard on handshakes, done cycle.
  always @(negedge clk) begin
    pair_t cur;
    pair_t e;
    cur = {row, col, last_col, last};
    if (held_v) check_value("hold_stable", cur, held_p);
    if (out_valid && out_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        check_value("extra_pair", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_value("row", row, e.r);
        check_value("col", col, e.c);
        check_value("last_col", last_col, e.lc);
        check_value("last", last, e.l);
      end
    end
    if (done) begin
      check_value("done_valid", out_valid, 1'b0);
      check_value("done_busy", busy, 1'b1);
      check_value("done_pending", exp_q.size(), 32'd0);
    end
    held_v = out_valid && !out_ready;
    held_p = cur;
  end

  // Queue the expected pair stream of one sweep; returns the pair count.
  function automatic int push_expected(input int nv, input bit tv);
    int nn;
    int p;
    pair_t e;
    nn = (nv > N_MAX) ? N_MAX : nv;
    p = 0;
    for (int r = 0; r < nn; r++) begin
      for (int c = (tv ? r : 0); c < nn; c++) begin
        e.r  = r[IW-1:0];
        e.c  = c[IW-1:0];
        e.lc = (c == nn - 1);
        e.l  = (c == nn - 1) && (r == nn - 1);
        exp_q.push_back(e);
        p++;
      end
    end
    return p;
  endfunction

  // One sweep; called at posedge+1 with the DUT idle, returns at posedge+1 idle.
  task automatic run_sweep(input int nv, input bit tv, input int mode, input int inject_k);
    int p;
    int cyc;
    int budget;
    bit got;
    logic [31:0] nv_w;
    p = push_expected(nv, tv);
    nv_w = nv;
    hs_count = 0;
    start = 1'b1;
    n = nv_w[IW:0];
    triangular = tv;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 5'd7;
    triangular = ~tv;
    out_ready = ready_pat(mode, 0);
    cyc = 0;
    got = 1'b0;
    budget = 4 * p + 8;
    while (!got && cyc < budget) begin
      @(negedge clk);
      if (cyc == 0) check_value("first_valid", out_valid, (p > 0));
      if (done) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        if (cyc == inject_k) begin
          start = 1'b1;
          n = 5'd2;
          triangular = 1'b1;
        end
        out_ready = ready_pat(mode, cyc);
      end
    end
    check_value("done_seen", got, 1'b1);
    if (mode == 0) check_value("no_bubbles", cyc, p);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_value("post_busy", busy, 1'b0);
    check_value("post_done", done, 1'b0);
    check_value("pair_count", hs_count, p);
    check_value("queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    out_ready = 1'b0;
  endtask

  initial begin
    int p;
    bit found;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_valid", out_valid, 1'b0);
    check_value("rst_row", row, 4'd0);
    check_value("rst_col", col, 4'd0);
    check_value("rst_last_col", last_col, 1'b0);
    check_value("rst_last", last, 1'b0);
    check_value("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_sweep(3, 1'b0, 0, -1);   // full 3x3
    run_sweep(4, 1'b1, 0, -1);   // triangular 4x4
    run_sweep(2, 1'b0, 1, -1);   // backpressure
    run_sweep(0, 1'b0, 0, -1);   // empty matrix
    run_sweep(1, 1'b0, 0, -1);   // single pair
    run_sweep(20, 1'b0, 0, -1);  // clamped to N_MAX
    run_sweep(5, 1'b1, 1, -1);   // triangular under backpressure
    run_sweep(3, 1'b0, 0, 3);    // start during RUN is ignored

    // Abort a full 3x3 sweep while (1,2) is presented.
    p = push_expected(3, 1'b0);
    start = 1'b1;
    n = 5'd3;
    triangular = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 4 * p && !found; i++) begin
      @(negedge clk);
      if (out_valid && row == 4'd1 && col == 4'd2) found = 1'b1;
    end
    check_value("abort_reach", found, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("abort_busy", busy, 1'b0);
    check_value("abort_valid", out_valid, 1'b0);
    check_value("abort_row", row, 4'd0);
    check_value("abort_col", col, 4'd0);
    check_value("abort_last_col", last_col, 1'b0);
    check_value("abort_last", last, 1'b0);
    check_value("abort_done", done, 1'b0);
    exp_q.delete();
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_value("abort_no_done", done, 1'b0);
      check_value("abort_idle", busy, 1'b0);
    end
    @(posedge clk);
    #1;
    run_sweep(2, 1'b0, 0, -1);   // fresh sweep after reset

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
